bitmap_layer: RTL and testbench

- Parametrised, frame-synchronous bitmap renderer. Successor to the fixed 640x480 background streamer.
- Draws an IMG_W x IMG_H image from external ROM at a runtime origin (pos_x, pos_y), with power-of-two integer scaling and colour-key transparency.
- Sits between the VGA timing generator (DrawX/DrawY) and the colour mapper. Feeds one layer into the mapper's priority mux.

---
 rtl/bitmap_layer.sv | 178 +++++++++++++++++
 tb/tb_bitmap_layer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bitmap_layer.sv
// bitmap_layer: frame-synchronous bitmap renderer.
// Places an IMG_W x IMG_H ROM image at a latched origin, applies power-of-two
// scaling and colour-key transparency, and emits one mapper layer with a
// fixed two-cycle latency from DrawX/DrawY sample to registered colour.
module bitmap_layer #(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int ADDR_W    = 19,
  parameter int CW        = 8,
  parameter int H_LAST    = 639,
  parameter int V_LAST    = 479,
  parameter int MAX_SHIFT = 2,
  parameter int KEY_EN    = 1,
  parameter logic [3*CW-1:0] KEY_COLOR = {(3*CW){1'b0}}
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              enable,
  input  logic              pix_en,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic [1:0]        scale_sel,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3*CW-1:0]   rom_data,
  output logic              layer_on,
  output logic [CW-1:0]     layer_R,
  output logic [CW-1:0]     layer_G,
  output logic [CW-1:0]     layer_B,
  output logic              frame_done
);

  typedef enum logic [1:0] {
    ST_OFF        = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_SCAN       = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [9:0]        pos_x_q, pos_x_d;
  logic [9:0]        pos_y_q, pos_y_d;
  logic [1:0]        shift_q, shift_d;
  logic              frame_done_q, frame_done_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              hit0_q, hit0_d;
  logic              vld0_q;
  logic              hit1_q, vld1_q;
  logic              layer_on_q, layer_on_d;
  logic [3*CW-1:0]   rgb_q, rgb_d;

  logic              frame_end_s;
  logic [1:0]        scale_clamp_s;
  logic [10:0]       x_rel_s, y_rel_s;
  logic [10:0]       x_scaled_s, y_scaled_s;
  logic [31:0]       x_lim_s, y_lim_s;
  logic              key_s;

  // Frame FSM: origin/scale are only sampled at the last visible pixel so a frame never tears
  always_comb begin
    state_d       = state_q;
    pos_x_d       = pos_x_q;
    pos_y_d       = pos_y_q;
    shift_d       = shift_q;
    frame_done_d  = 1'b0;
    frame_end_s   = pix_en && (DrawX == 10'(H_LAST)) && (DrawY == 10'(V_LAST));
    scale_clamp_s = (scale_sel > 2'(MAX_SHIFT)) ? 2'(MAX_SHIFT) : scale_sel;
    if (!enable) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_WAIT_FRAME;
        end
        ST_WAIT_FRAME: begin
          if (frame_end_s) begin
            state_d = ST_SCAN;
            pos_x_d = pos_x;
            pos_y_d = pos_y;
            shift_d = scale_clamp_s;
          end else begin
            state_d = ST_WAIT_FRAME;
          end
        end
        ST_SCAN: begin
          if (frame_end_s) begin
            pos_x_d      = pos_x;
            pos_y_d      = pos_y;
            shift_d      = scale_clamp_s;
            frame_done_d = 1'b1;
          end else begin
            frame_done_d = 1'b0;
          end
        end
        default: begin
          state_d = ST_OFF;
        end
      endcase
    end
  end

  // Stage 0: hit test against the latched origin and ROM address generation
  always_comb begin
    x_rel_s    = {1'b0, DrawX} - {1'b0, pos_x_q};
    y_rel_s    = {1'b0, DrawY} - {1'b0, pos_y_q};
    x_scaled_s = x_rel_s >> shift_q;
    y_scaled_s = y_rel_s >> shift_q;
    x_lim_s    = 32'(IMG_W) << shift_q;
    y_lim_s    = 32'(IMG_H) << shift_q;
    // Enable is part of the test so the sample on the disabling edge is already dark
    hit0_d     = (state_q == ST_SCAN) && enable && pix_en &&
                 (DrawX >= pos_x_q) && (DrawY >= pos_y_q) &&
                 (32'(x_rel_s) < x_lim_s) && (32'(y_rel_s) < y_lim_s);
    if (hit0_d) begin
      rom_addr_d = ADDR_W'(y_scaled_s) * ADDR_W'(IMG_W) + ADDR_W'(x_scaled_s);
    end else begin
      rom_addr_d = rom_addr_q;
    end
  end

  // Stage 2: resolve transparency once ROM data for the stage-1 sample is present
  always_comb begin
    key_s      = (KEY_EN != 0) && (rom_data == KEY_COLOR);
    layer_on_d = layer_on_q;
    rgb_d      = rgb_q;
    if (vld1_q) begin
      if (hit1_q && !key_s) begin
        layer_on_d = 1'b1;
        rgb_d      = rom_data;
      end else begin
        layer_on_d = 1'b0;
        rgb_d      = {(3*CW){1'b0}};
      end
    end else begin
      layer_on_d = layer_on_q;
      rgb_d      = rgb_q;
    end
  end

  // State, latched frame parameters and the free-running pixel pipeline
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= ST_OFF;
      pos_x_q      <= 10'd0;
      pos_y_q      <= 10'd0;
      shift_q      <= 2'd0;
      frame_done_q <= 1'b0;
      rom_addr_q   <= {ADDR_W{1'b0}};
      hit0_q       <= 1'b0;
      vld0_q       <= 1'b0;
      hit1_q       <= 1'b0;
      vld1_q       <= 1'b0;
      layer_on_q   <= 1'b0;
      rgb_q        <= {(3*CW){1'b0}};
    end else begin
      state_q      <= state_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      shift_q      <= shift_d;
      frame_done_q <= frame_done_d;
      rom_addr_q   <= rom_addr_d;
      hit0_q       <= hit0_d;
      vld0_q       <= pix_en;
      hit1_q       <= hit0_q;
      vld1_q       <= vld0_q;
      layer_on_q   <= layer_on_d;
      rgb_q        <= rgb_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign frame_done = frame_done_q;
  assign layer_on   = layer_on_q;
  assign layer_R    = rgb_q[3*CW-1:2*CW];
  assign layer_G    = rgb_q[2*CW-1:CW];
  assign layer_B    = rgb_q[CW-1:0];

endmodule

// File: tb/tb_bitmap_layer.sv
// tb_bitmap_layer: scoreboard bench for bitmap_layer on a tiny 8x4 screen
// with a 4x2 image. A behavioural model predicts each sample's colour when it
// is driven; the prediction is popped and compared two edges later.
module tb_bitmap_layer;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        enable;
  logic        pix_en;
  logic [9:0]  DrawX, DrawY, pos_x, pos_y;
  logic [1:0]  scale_sel;
  logic [3:0]  rom_addr;
  logic [23:0] rom_data;
  logic        layer_on;
  logic [7:0]  layer_R, layer_G, layer_B;
  logic        frame_done;

  logic [23:0] rom [0:15];

  typedef struct packed {
    logic        vld;
    logic        on;
    logic [23:0] rgb;
  } exp_t;
  exp_t sb_q[$];

  int          checks = 0;
  int          errors = 0;
  int          m_st;
  int          m_px, m_py, m_sh;
  logic [3:0]  m_addr;
  logic        m_last_on;
  logic [23:0] m_last_rgb;

  bitmap_layer #(
    .IMG_W(4), .IMG_H(2), .ADDR_W(4), .CW(8), .H_LAST(7), .V_LAST(3),
    .MAX_SHIFT(2), .KEY_EN(1), .KEY_COLOR(24'h000000)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .enable(enable), .pix_en(pix_en),
    .DrawX(DrawX), .DrawY(DrawY), .pos_x(pos_x), .pos_y(pos_y),
    .scale_sel(scale_sel), .rom_addr(rom_addr), .rom_data(rom_data),
    .layer_on(layer_on), .layer_R(layer_R), .layer_G(layer_G),
    .layer_B(layer_B), .frame_done(frame_done)
  );

  always #5 Clk = ~Clk;

  // Synchronous ROM with one-cycle registered read
  always @(posedge Clk) rom_data <= rom[rom_addr];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st       = 0;
    m_px       = 0;
    m_py       = 0;
    m_sh       = 0;
    m_addr     = 4'd0;
    m_last_on  = 1'b0;
    m_last_rgb = 24'h0;
    sb_q.delete();
  endtask

  // One pixel: predict, clock, then check frame_done, rom_addr and the sample from two edges ago
  task automatic drive_cycle(input int x, input int y, input bit pen);
    bit          fe, hit, efd, latch;
    int          xr, yr, a, nst;
    exp_t        e;
    logic [23:0] d;
    DrawX  = 10'(x);
    DrawY  = 10'(y);
    pix_en = pen;
    fe  = pen && (x == 7) && (y == 3);
    xr  = x - m_px;
    yr  = y - m_py;
    hit = (m_st == 2) && enable && pen && (x >= m_px) && (y >= m_py) &&
          (xr < (4 << m_sh)) && (yr < (2 << m_sh));
    e = '0;
    e.vld = pen;
    a = 0;
    if (hit) begin
      a = (yr >> m_sh) * 4 + (xr >> m_sh);
      d = rom[a];
      if (d != 24'h0) begin
        e.on  = 1'b1;
        e.rgb = d;
      end
    end
    efd   = (m_st == 2) && enable && fe;
    nst   = m_st;
    latch = 1'b0;
    if (!enable) nst = 0;
    else if (m_st == 0) nst = 1;
    else if (fe) begin
      nst   = 2;
      latch = 1'b1;
    end
    sb_q.push_back(e);
    @(posedge Clk);
    #1;
    m_st = nst;
    if (latch) begin
      m_px = int'(pos_x);
      m_py = int'(pos_y);
      m_sh = (int'(scale_sel) > 2) ? 2 : int'(scale_sel);
    end
    if (hit) m_addr = 4'(a);
    check_val("frame_done", {31'd0, frame_done}, {31'd0, efd});
    check_val("rom_addr", {28'd0, rom_addr}, {28'd0, m_addr});
    if (sb_q.size() == 3) begin
      e = sb_q.pop_front();
      if (e.vld) begin
        m_last_on  = e.on;
        m_last_rgb = e.rgb;
      end
      check_val("layer_on", {31'd0, layer_on}, {31'd0, m_last_on});
      check_val("layer_rgb", {8'd0, layer_R, layer_G, layer_B}, {8'd0, m_last_rgb});
    end
  endtask

  // mode 0 plain, 1 pos_x moves mid-frame, 2 enable drops/returns, 3 pix_en gaps in row 2
  task automatic run_frame(input int mode);
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 8; x++) begin
        if (mode == 1 && y == 2 && x == 0) pos_x = 10'd4;
        if (mode == 2 && y == 1 && x == 3) enable = 1'b0;
        if (mode == 2 && y == 1 && x == 5) enable = 1'b1;
        if (mode == 3 && y == 2) drive_cycle(x, y, 1'b0);
        drive_cycle(x, y, 1'b1);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = {8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i)};
    Reset_n   = 1'b0;
    enable    = 1'b0;
    pix_en    = 1'b0;
    DrawX     = 10'd0;
    DrawY     = 10'd0;
    pos_x     = 10'd2;
    pos_y     = 10'd1;
    scale_sel = 2'd0;
    repeat (3) @(posedge Clk);
    #1;
    check_val("rst_rom_addr", {28'd0, rom_addr}, 32'd0);
    check_val("rst_layer_on", {31'd0, layer_on}, 32'd0);
    check_val("rst_rgb", {8'd0, layer_R, layer_G, layer_B}, 32'd0);
    check_val("rst_frame_done", {31'd0, frame_done}, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    model_reset();
    enable = 1'b1;

    run_frame(0);                      // waiting frame, no hits
    run_frame(0);                      // origin (2,1), scale 1x
    drive_cycle(3, 2, 1'b1);
    check_val("addr_3_2", {28'd0, rom_addr}, 32'd5);
    drive_cycle(6, 1, 1'b1);
    drive_cycle(1, 1, 1'b1);
    check_val("on_3_2", {31'd0, layer_on}, 32'd1);
    check_val("rgb_3_2", {8'd0, layer_R, layer_G, layer_B}, 32'h00152535);
    drive_cycle(0, 0, 1'b1);
    check_val("off_6_1", {31'd0, layer_on}, 32'd0);
    drive_cycle(0, 0, 1'b1);
    check_val("off_1_1", {31'd0, layer_on}, 32'd0);

    run_frame(1);                      // pos_x 2->4 mid-frame, still drawn at 2
    pos_x = 10'd2;
    run_frame(0);                      // drawn at 4
    scale_sel = 2'd1;
    run_frame(0);                      // drawn at 2, 1x; latches 2x
    drive_cycle(5, 2, 1'b1);
    check_val("addr_5_2_x2", {28'd0, rom_addr}, 32'd1);
    drive_cycle(7, 3, 1'b1);
    check_val("addr_7_3_x2", {28'd0, rom_addr}, 32'd6);
    run_frame(0);                      // 2x frame
    scale_sel = 2'd3;
    run_frame(0);                      // 2x; latches clamped 4x
    run_frame(3);                      // 4x with pix_en gaps
    scale_sel = 2'd0;
    run_frame(0);
    run_frame(0);

    rom[5] = 24'h000000;               // key colour
    run_frame(0);
    rom[5] = 24'hFF0000;
    run_frame(0);

    run_frame(2);                      // disable at (3,1), re-enable at (5,1)
    run_frame(0);                      // hits resume

    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 8; x++) begin
        if (!(y == 2 && x > 3)) drive_cycle(x, y, 1'b1);
      end
    end
    #2;
    Reset_n = 1'b0;
    #1;
    check_val("arst_rom_addr", {28'd0, rom_addr}, 32'd0);
    check_val("arst_layer_on", {31'd0, layer_on}, 32'd0);
    check_val("arst_rgb", {8'd0, layer_R, layer_G, layer_B}, 32'd0);
    check_val("arst_frame_done", {31'd0, frame_done}, 32'd0);
    @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    model_reset();
    run_frame(0);                      // no hits until first frame end
    run_frame(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
